// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - WM8731 init constants, register word table and sequencer state type
package codec_cfg_pkg;

    localparam logic [7:0] WM8731_ADDR_W = 8'h34;
    localparam int         N_WORDS       = 9;
    localparam int         WORD_IDX_W    = $clog2(N_WORDS);

    // Each word is {reg[6:0], data[8:0]}, written in this order after reset
    localparam logic [15:0] INIT_TABLE [N_WORDS] = '{
        16'h1E00,  // reset
        16'h0C00,  // power all on
        16'h0E02,  // I2S 16-bit slave
        16'h1000,  // 48 kHz normal mode
        16'h0812,  // DAC select, mic mute
        16'h0A00,  // DAC unmute
        16'h0479,  // left headphone 0 dB
        16'h0679,  // right headphone 0 dB
        16'h1201   // active
    };

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        GAP,
        DONE,
        ERROR
    } init_state_t;

    // Byte 0 of a transaction is the device address, bytes 1 and 2 the table word
    function automatic logic [7:0] tx_byte(input logic [WORD_IDX_W-1:0] word_idx,
                                           input logic [1:0]            byte_idx);
        logic [15:0] word;
        word = INIT_TABLE[word_idx];
        case (byte_idx)
            2'd0:    tx_byte = WM8731_ADDR_W;
            2'd1:    tx_byte = word[15:8];
            default: tx_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/codec_i2c_init_if.sv
// rtl/codec_i2c_init_if.sv - codec I2C pin bundle with open-drain SDA enable
interface codec_i2c_init_if;
    logic i2c_sclk;
    logic i2c_sda_oe;
    logic i2c_sda_in;

    modport master (
        output i2c_sclk,
        output i2c_sda_oe,
        input  i2c_sda_in
    );

    modport slave (
        input  i2c_sclk,
        input  i2c_sda_oe,
        output i2c_sda_in
    );
endinterface

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter-bit tick generator; clear restarts a full quarter period
module i2c_qtick #(
    parameter int SYSCLK_FREQUENCY = 1333,
    parameter int I2C_KHZ          = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic qtick
);
    localparam int               DIV   = SYSCLK_FREQUENCY * 100 / (4 * I2C_KHZ);
    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign qtick = (cnt == LAST);
endmodule

// File: rtl/codec_i2c_init.sv
// rtl/codec_i2c_init.sv - writes the WM8731 init table over I2C after reset or reinit
module codec_i2c_init
    import codec_cfg_pkg::*;
#(
    parameter int SYSCLK_FREQUENCY = 1333,
    parameter int I2C_KHZ          = 100,
    parameter int MAX_RETRY        = 3,
    parameter int GAP_TICKS        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reinit,
    codec_i2c_init_if.master        i2c,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
    localparam int GAP_W   = $clog2(GAP_TICKS + 1);

    init_state_t             state, state_nxt;
    logic [1:0]              phase, phase_nxt;
    logic [2:0]              bit_idx, bit_nxt;
    logic [1:0]              byte_idx, byte_nxt;
    logic [WORD_IDX_W-1:0]   word_idx, word_nxt;
    logic [RETRY_W-1:0]      retry_cnt, retry_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic                    nack, nack_nxt;
    logic                    restart;
    logic                    qtick;
    logic                    sda_meta, sda_sync;
    logic [7:0]              cur_byte;
    logic                    cur_bit;

    i2c_qtick #(
        .SYSCLK_FREQUENCY(SYSCLK_FREQUENCY),
        .I2C_KHZ         (I2C_KHZ)
    ) u_qtick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear((state == IDLE) || restart),
        .qtick(qtick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= i2c.i2c_sda_in;
            sda_sync <= sda_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= 3'd7;
            byte_idx  <= '0;
            word_idx  <= '0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            nack      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            word_idx  <= word_nxt;
            retry_cnt <= retry_nxt;
            gap_cnt   <= gap_nxt;
            nack      <= nack_nxt;
        end
    end

    assign cur_byte = tx_byte(word_idx, byte_idx);
    assign cur_bit  = cur_byte[bit_idx];

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        word_nxt  = word_idx;
        retry_nxt = retry_cnt;
        gap_nxt   = gap_cnt;
        nack_nxt  = nack;
        restart   = 1'b0;
        case (state)
            IDLE:        restart = 1'b1;
            DONE, ERROR: restart = reinit;
            START: if (qtick) begin
                phase_nxt = phase + 2'd1;
                if (phase == 2'd3) begin
                    state_nxt = BIT;
                    bit_nxt   = 3'd7;
                    byte_nxt  = 2'd0;
                end
            end
            BIT: if (qtick) begin
                phase_nxt = phase + 2'd1;
                if (phase == 2'd3) begin
                    if (bit_idx == 3'd0) state_nxt = ACK;
                    else                 bit_nxt   = bit_idx - 3'd1;
                end
            end
            ACK: if (qtick) begin
                phase_nxt = phase + 2'd1;
                if (phase == 2'd2) nack_nxt = sda_sync;
                if (phase == 2'd3) begin
                    if (nack || byte_idx == 2'd2) begin
                        state_nxt = STOP;
                    end else begin
                        state_nxt = BIT;
                        byte_nxt  = byte_idx + 2'd1;
                        bit_nxt   = 3'd7;
                    end
                end
            end
            STOP: if (qtick) begin
                phase_nxt = phase + 2'd1;
                if (phase == 2'd3) begin
                    if (nack && retry_cnt == RETRY_W'(MAX_RETRY)) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                    end
                end
            end
            GAP: if (qtick) begin
                gap_nxt = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                    state_nxt = START;
                    phase_nxt = 2'd0;
                    byte_nxt  = 2'd0;
                    nack_nxt  = 1'b0;
                    // A NACKed word is resent as-is; an ACKed one advances the table
                    if (nack) begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                    end else begin
                        retry_nxt = '0;
                        if (word_idx == WORD_IDX_W'(N_WORDS - 1)) state_nxt = DONE;
                        else                                     word_nxt  = word_idx + WORD_IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (restart) begin
            state_nxt = START;
            phase_nxt = 2'd0;
            bit_nxt   = 3'd7;
            byte_nxt  = 2'd0;
            word_nxt  = '0;
            retry_nxt = '0;
            gap_nxt   = '0;
            nack_nxt  = 1'b0;
        end
    end

    // SDA only moves while SCL is low, except the deliberate START and STOP edges
    always_comb begin
        i2c.i2c_sclk   = 1'b1;
        i2c.i2c_sda_oe = 1'b0;
        case (state)
            START: begin
                i2c.i2c_sclk   = (phase < 2'd2);
                i2c.i2c_sda_oe = (phase != 2'd0);
            end
            BIT: begin
                i2c.i2c_sclk   = (phase == 2'd1) || (phase == 2'd2);
                i2c.i2c_sda_oe = ~cur_bit;
            end
            ACK: begin
                i2c.i2c_sclk   = (phase == 2'd1) || (phase == 2'd2);
                i2c.i2c_sda_oe = 1'b0;
            end
            STOP: begin
                i2c.i2c_sclk   = (phase != 2'd0);
                i2c.i2c_sda_oe = (phase < 2'd2);
            end
            default: begin
                i2c.i2c_sclk   = 1'b1;
                i2c.i2c_sda_oe = 1'b0;
            end
        endcase
    end

    assign busy  = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign done  = (state == DONE);
    assign error = (state == ERROR);
endmodule

// File: tb/tb_codec_i2c_init.sv
// tb/tb_codec_i2c_init.sv - directed bench with an ACK/NACK slave and byte-level bus monitor
module tb_codec_i2c_init;
    logic clk = 1'b0;
    logic rst_n, rst_def_n, reinit;
    logic busy, done, error;
    logic def_busy, def_done, def_error;

    always #5 clk = ~clk;

    codec_i2c_init_if bus ();
    codec_i2c_init_if bus_def ();

    logic slave_low = 1'b0;
    assign bus.i2c_sda_in     = ~(bus.i2c_sda_oe | slave_low);
    assign bus_def.i2c_sda_in = ~bus_def.i2c_sda_oe;

    // Fast instance: DIV = 12*100/400 = 3
    codec_i2c_init #(
        .SYSCLK_FREQUENCY(12), .I2C_KHZ(100), .MAX_RETRY(3), .GAP_TICKS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .i2c(bus),
        .busy(busy), .done(done), .error(error)
    );

    codec_i2c_init dut_def (
        .clk(clk), .rst_n(rst_def_n), .reinit(1'b0), .i2c(bus_def),
        .busy(def_busy), .done(def_done), .error(def_error)
    );

    logic [15:0] tbl [9] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0812,
                             16'h0A00, 16'h0479, 16'h0679, 16'h1201};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave: decodes bytes, drives ACK unless told to NACK
    logic       clr_req = 1'b1;
    logic [7:0] nack_hi = 8'h00;
    int         nack_limit = 0;
    int         nack_used, n_start, n_stop, n_both, bit_cnt, byte_in_txn;
    logic [7:0] shreg, txn_hi;
    logic [7:0] got [$];
    logic       scl_q = 1'b1, sda_q = 1'b1, m_scl, m_sda;

    always @(negedge clk) begin
        m_scl = bus.i2c_sclk;
        m_sda = ~(bus.i2c_sda_oe | slave_low);
        if (clr_req) begin
            got.delete();
            n_start = 0; n_stop = 0; n_both = 0; nack_used = 0;
            bit_cnt = 0; byte_in_txn = 0; slave_low = 1'b0;
        end else begin
            if (m_scl && scl_q && sda_q && !m_sda) begin
                n_start++; bit_cnt = 0; byte_in_txn = 0; slave_low = 1'b0;
            end else if (m_scl && scl_q && !sda_q && m_sda) begin
                n_stop++; bit_cnt = 0; slave_low = 1'b0;
            end
            if ((m_scl != scl_q) && (m_sda != sda_q)) n_both++;
            if (m_scl && !scl_q) begin
                if (bit_cnt < 8) begin
                    shreg = {shreg[6:0], m_sda};
                    bit_cnt++;
                end else begin
                    bit_cnt = 9;
                end
            end else if (!m_scl && scl_q) begin
                if (bit_cnt == 8) begin
                    got.push_back(shreg);
                    if (byte_in_txn == 1) txn_hi = shreg;
                    slave_low = 1'b1;
                    if (byte_in_txn == 2 && txn_hi == nack_hi && nack_used < nack_limit) begin
                        slave_low = 1'b0;
                        nack_used++;
                    end
                    byte_in_txn++;
                end else if (bit_cnt == 9) begin
                    slave_low = 1'b0;
                    bit_cnt = 0;
                end
            end
        end
        scl_q = m_scl;
        sda_q = m_sda;
    end

    logic [7:0] exp_q [$];

    task automatic exp_word(input int w, input int times);
        logic [15:0] word;
        word = tbl[w];
        repeat (times) begin
            exp_q.push_back(8'h34);
            exp_q.push_back(word[15:8]);
            exp_q.push_back(word[7:0]);
        end
    endtask

    task automatic cmp_run(input string tag, input int n_txn);
        int n;
        check({tag, " nbytes"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
        check({tag, " starts"}, n_start, n_txn);
        check({tag, " stops"}, n_stop, n_txn);
        check({tag, " sda moved with scl"}, n_both, 0);
    endtask

    task automatic clr_mon();
        clr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic pulse_reinit();
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " finished"}, done | error, 1'b1);
    endtask

    task automatic wait_scl(input logic lvl, input string tag);
        int n = 0;
        while (bus.i2c_sclk !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.i2c_sclk, lvl);
    endtask

    int n, hi;
    logic oe_seen;

    initial begin
        rst_n = 1'b0; rst_def_n = 1'b0; reinit = 1'b0;
        repeat (4) @(negedge clk);
        clr_req = 1'b0;
        check("rst sclk", bus.i2c_sclk, 1'b1);
        check("rst sda_oe", bus.i2c_sda_oe, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst error", error, 1'b0);

        // Default-rate instance: SCL high time of the first data bit
        rst_def_n = 1'b1;
        n = 0;
        while (bus_def.i2c_sclk && n < 5000) begin @(negedge clk); n++; end
        while (!bus_def.i2c_sclk && n < 5000) begin @(negedge clk); n++; end
        hi = 0; oe_seen = 1'b1;
        while (bus_def.i2c_sclk && hi < 5000) begin
            if (!bus_def.i2c_sda_oe) oe_seen = 1'b0;
            hi++;
            @(negedge clk);
        end
        check("default scl high clks", hi, 666);
        check("default first bit low", oe_seen, 1'b1);
        rst_def_n = 1'b0;

        // Full table with an always-ACK slave
        rst_n = 1'b1;
        @(negedge clk);
        check("start busy", busy, 1'b1);
        check("start done", done, 1'b0);
        wait_end("run1");
        exp_q.delete();
        for (int w = 0; w < 9; w++) exp_word(w, 1);
        cmp_run("run1", 9);
        check("run1 first byte", got.size() > 0 ? got[0] : 8'hxx, 8'h34);
        check("run1 word2 hi", got.size() > 7 ? got[7] : 8'hxx, 8'h0E);
        check("run1 word2 lo", got.size() > 8 ? got[8] : 8'hxx, 8'h02);
        check("run1 done", done, 1'b1);
        check("run1 busy", busy, 1'b0);
        check("run1 error", error, 1'b0);
        check("run1 idle sclk", bus.i2c_sclk, 1'b1);
        check("run1 idle sda_oe", bus.i2c_sda_oe, 1'b0);

        // reinit from DONE, plus an ignored reinit while busy
        clr_mon();
        pulse_reinit();
        check("reinit done clr", done, 1'b0);
        check("reinit busy", busy, 1'b1);
        repeat (500) @(negedge clk);
        pulse_reinit();
        check("busy reinit ignored", busy, 1'b1);
        wait_end("run2");
        cmp_run("run2", 9);
        check("run2 done", done, 1'b1);

        // Word 4 NACKed twice, then accepted
        clr_mon();
        nack_hi = 8'h08; nack_limit = 2;
        pulse_reinit();
        wait_end("nack2");
        exp_q.delete();
        for (int w = 0; w < 9; w++) exp_word(w, (w == 4) ? 3 : 1);
        cmp_run("nack2", 11);
        check("nack2 done", done, 1'b1);
        check("nack2 error", error, 1'b0);

        // Word 1 NACKed forever: one attempt plus three retries, then ERROR
        clr_mon();
        nack_hi = 8'h0C; nack_limit = 1000;
        pulse_reinit();
        wait_end("nackp");
        exp_q.delete();
        exp_word(0, 1);
        exp_word(1, 4);
        cmp_run("nackp", 5);
        check("nackp error", error, 1'b1);
        check("nackp done", done, 1'b0);
        check("nackp busy", busy, 1'b0);

        // reinit from ERROR, then reset during a data bit of word 3
        clr_mon();
        nack_limit = 0;
        pulse_reinit();
        check("reinit error clr", error, 1'b0);
        n = 0;
        while (got.size() < 10 && n < 20000) begin @(negedge clk); n++; end
        check("reach word3", got.size() >= 10, 1'b1);
        wait_scl(1'b1, "word3 ack high");
        wait_scl(1'b0, "word3 ack low");
        wait_scl(1'b1, "word3 bit7 high");
        check("word3 bit7 driven low", bus.i2c_sda_oe, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset sclk", bus.i2c_sclk, 1'b1);
        check("midreset sda_oe", bus.i2c_sda_oe, 1'b0);
        check("midreset busy", busy, 1'b0);
        clr_mon();
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun busy", busy, 1'b1);
        wait_end("rerun");
        exp_q.delete();
        for (int w = 0; w < 9; w++) exp_word(w, 1);
        cmp_run("rerun", 9);
        check("rerun byte0", got.size() > 0 ? got[0] : 8'hxx, 8'h34);
        check("rerun byte1", got.size() > 1 ? got[1] : 8'hxx, 8'h1E);
        check("rerun done", done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
